int_ctrl: RTL and testbench

//  Memory-mapped interrupt controller upstream of the processor core; drives core INT0/INT1.

---
 rtl/int_ctrl_pkg.sv | 19 +
 rtl/int_sync_edge.sv | 13 +
 rtl/int_ctrl.sv | 69 ++++++
 tb/tb_int_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: register offsets, vector flag and helpers shared by the interrupt controller.
package int_ctrl_pkg;
  localparam logic [15:0] INTC_VEC_VALID = 16'h8000;
  typedef enum logic [2:0] {
    R_PEND   = 3'd0,
    R_MASK   = 3'd1,
    R_ROUTE  = 3'd2,
    R_TRIG   = 3'd3,
    R_VECTOR = 3'd4,
    R_SOFT   = 3'd5
  } reg_e;
  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd, input logic [15:0] be);
    return (old & ~be) | (wd & be);
  endfunction
  function automatic logic [15:0] prio_vec(input logic [15:0] req);
    prio_vec = 16'h0;
    for (int i = 15; i >= 0; i--) if (req[i]) prio_vec = INTC_VEC_VALID | 16'(i);
  endfunction
endpackage

// File: rtl/int_sync_edge.sv
// int_sync_edge: two-flop synchroniser plus one edge flop; outputs level and rising-edge pulse.
module int_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  output logic level,
  output logic rise
);
  logic [2:0] s;
  always_ff @(posedge clk) s <= rst ? 3'b0 : {s[1:0], irq};
  assign level = s[1];
  assign rise = s[1] & ~s[2];
endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: memory-mapped interrupt controller driving INT0/INT1.
// Define INTC_SOFT_IRQ_EN to enable the write-1-to-set SOFT register.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int NSRC = 8,
  parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [15:0]     ADDR,
  input  logic [15:0]     WDATA,
  input  logic            RDN,
  input  logic            WRN0,
  input  logic            WRN1,
  input  logic [NSRC-1:0] IRQ,
  output logic [15:0]     RDATA,
  output logic            SEL,
  output logic            INT0,
  output logic            INT1
);
  localparam logic [15:0] SRC = 16'((32'd1 << NSRC) - 32'd1);
  logic [15:0] pend, mask, route, trig, sticky, sticky_n;
  logic [15:0] level, rise, lanes, w1c, soft_set, vector, rsel;
  logic wrn0_q, wrn1_q, hit, unused_ok;
  reg_e off;
  for (genvar i = 0; i < 16; i++) begin : g_src
    if (i < NSRC) begin : g_on
      int_sync_edge u_sync (.clk(CLK), .rst(RESET), .irq(IRQ[i]), .level(level[i]), .rise(rise[i]));
    end else begin : g_off
      assign level[i] = 1'b0;
      assign rise[i] = 1'b0;
    end
  end
  assign unused_ok = ADDR[0];
  assign hit = ADDR[15:4] == BASE_ADDR[15:4];
  assign off = reg_e'(ADDR[3:1]);
  assign SEL = hit & ~RDN;
  // A lane writes only on the first cycle its strobe is seen low.
  assign lanes = hit ? {{8{~WRN1 & wrn1_q}}, {8{~WRN0 & wrn0_q}}} : 16'h0;
  assign w1c = off == R_PEND ? WDATA & lanes : 16'h0;
`ifdef INTC_SOFT_IRQ_EN
  assign soft_set = off == R_SOFT ? WDATA & lanes & SRC : 16'h0;
`else
  assign soft_set = 16'h0;
`endif
  // Latched events survive until W1C; a new event on the clearing edge wins.
  assign sticky_n = (soft_set | (trig & rise) | (sticky & ~w1c)) & SRC;
  assign vector = prio_vec(pend & mask);
  assign rsel = off == R_PEND ? pend : off == R_MASK ? mask : off == R_ROUTE ? route :
                off == R_TRIG ? trig : off == R_VECTOR ? vector : 16'h0;
  assign RDATA = SEL ? rsel : 16'h0;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      {pend, mask, route, trig, sticky} <= '0;
      {wrn0_q, wrn1_q, INT0, INT1} <= '0;
    end else begin
      wrn0_q <= WRN0;
      wrn1_q <= WRN1;
      sticky <= sticky_n;
      pend <= sticky_n | (~trig & level & SRC);
      mask <= off == R_MASK ? merge(mask, WDATA, lanes) & SRC : mask;
      route <= off == R_ROUTE ? merge(route, WDATA, lanes) & SRC : route;
      trig <= off == R_TRIG ? merge(trig, WDATA, lanes) & SRC : trig;
      INT0 <= |(pend & mask & ~route);
      INT1 <= |(pend & mask & route);
    end
  end
endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed self-checking bench for int_ctrl (NSRC=16).
module tb_int_ctrl;
  localparam logic [15:0] BASE = 16'hFF00;
`ifdef INTC_SOFT_IRQ_EN
  localparam logic [15:0] SOFT_EXP = 16'h0080;
`else
  localparam logic [15:0] SOFT_EXP = 16'h0000;
`endif
  logic CLK = 0, RESET = 1, RDN = 1, WRN0 = 1, WRN1 = 1;
  logic [15:0] ADDR = 16'h0, WDATA = 16'h0, IRQ = 16'h0, RDATA, d;
  logic SEL, INT0, INT1;
  int vectors = 0, miscompares = 0;
  int_ctrl #(.NSRC(16), .BASE_ADDR(BASE)) dut (
    .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .WDATA(WDATA), .RDN(RDN), .WRN0(WRN0), .WRN1(WRN1),
    .IRQ(IRQ), .RDATA(RDATA), .SEL(SEL), .INT0(INT0), .INT1(INT1)
  );
  always #5 CLK = ~CLK;
  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic rd(input logic [3:0] o, output logic [15:0] v);
    ADDR = BASE | 16'(o);
    RDN = 0;
    #1;
    v = RDATA;
    RDN = 1;
  endtask
  task automatic wr(input logic [3:0] o, input logic [15:0] v, input logic l0, input logic l1);
    ADDR = BASE | 16'(o);
    WDATA = v;
    WRN0 = ~l0;
    WRN1 = ~l1;
    tick();
    WRN0 = 1;
    WRN1 = 1;
    tick();
  endtask
  task automatic test_reset;
    wr(4'h2, 16'h0001, 1, 1);
    IRQ[0] = 1;
    tick(4);
    vectors++; if (INT0 !== 1'b1) begin miscompares++; $display("FAIL pre_reset_int0: got %b want 1", INT0); end
    wr(4'h4, 16'h00F0, 1, 1);
    wr(4'h6, 16'h0F00, 1, 1);
    ADDR = BASE | 16'h2; WDATA = 16'hFFFF; WRN0 = 0; WRN1 = 0; RESET = 1; IRQ = 16'h0;
    tick(2);
    RESET = 0; WRN0 = 1; WRN1 = 1;
    tick();
    vectors++; if (INT0 !== 1'b0) begin miscompares++; $display("FAIL reset_int0: got %b want 0", INT0); end
    vectors++; if (INT1 !== 1'b0) begin miscompares++; $display("FAIL reset_int1: got %b want 0", INT1); end
    for (int o = 0; o < 16; o += 2) begin
      rd(4'(o), d);
      vectors++; if (d !== 16'h0) begin miscompares++; $display("FAIL reset_reg+%0h: got %h want 0000", o, d); end
    end
    tick();
  endtask
  task automatic test_edge;
    wr(4'h6, 16'h0001, 1, 1);
    wr(4'h2, 16'h0001, 1, 1);
    IRQ[0] = 1;
    tick();
    IRQ[0] = 0;
    tick(2);
    rd(4'h0, d);
    vectors++; if (d !== 16'h0001) begin miscompares++; $display("FAIL edge_pend_e3: got %h want 0001", d); end
    vectors++; if (INT0 !== 1'b0) begin miscompares++; $display("FAIL edge_int0_e3: got %b want 0", INT0); end
    tick();
    vectors++; if (INT0 !== 1'b1) begin miscompares++; $display("FAIL edge_int0_e4: got %b want 1", INT0); end
    rd(4'h8, d);
    vectors++; if (d !== 16'h8000) begin miscompares++; $display("FAIL edge_vector: got %h want 8000", d); end
    ADDR = BASE; WDATA = 16'h0001; WRN0 = 0;
    tick();
    WRN0 = 1;
    rd(4'h0, d);
    vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL edge_w1c_pend: got %h want 0000", d); end
    vectors++; if (INT0 !== 1'b1) begin miscompares++; $display("FAIL edge_int0_lag: got %b want 1", INT0); end
    tick();
    vectors++; if (INT0 !== 1'b0) begin miscompares++; $display("FAIL edge_int0_clr: got %b want 0", INT0); end
  endtask
  task automatic test_level;
    wr(4'h4, 16'h0004, 1, 1);
    wr(4'h2, 16'h0004, 1, 1);
    IRQ[2] = 1;
    tick(4);
    vectors++; if (INT1 !== 1'b1) begin miscompares++; $display("FAIL level_int1: got %b want 1", INT1); end
    vectors++; if (INT0 !== 1'b0) begin miscompares++; $display("FAIL level_int0: got %b want 0", INT0); end
    rd(4'h8, d);
    vectors++; if (d !== 16'h8002) begin miscompares++; $display("FAIL level_vector: got %h want 8002", d); end
    wr(4'h0, 16'h0004, 1, 1);
    rd(4'h0, d);
    vectors++; if (d !== 16'h0004) begin miscompares++; $display("FAIL level_w1c_ignored: got %h want 0004", d); end
    IRQ[2] = 0;
    tick(2);
    rd(4'h0, d);
    vectors++; if (d !== 16'h0004) begin miscompares++; $display("FAIL level_drop_e2: got %h want 0004", d); end
    tick();
    rd(4'h0, d);
    vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL level_drop_e3: got %h want 0000", d); end
  endtask
  task automatic test_priority;
    wr(4'h6, 16'h0029, 1, 1);
    wr(4'h4, 16'h0000, 1, 1);
    IRQ[3] = 1; IRQ[5] = 1;
    tick();
    IRQ[3] = 0; IRQ[5] = 0;
    tick(3);
    wr(4'h2, 16'h0028, 1, 1);
    rd(4'h0, d);
    vectors++; if (d !== 16'h0028) begin miscompares++; $display("FAIL prio_pend: got %h want 0028", d); end
    rd(4'h8, d);
    vectors++; if (d !== 16'h8003) begin miscompares++; $display("FAIL prio_vec_3: got %h want 8003", d); end
    wr(4'h2, 16'h0020, 1, 1);
    rd(4'h8, d);
    vectors++; if (d !== 16'h8005) begin miscompares++; $display("FAIL prio_vec_5: got %h want 8005", d); end
    vectors++; if (INT0 !== 1'b1) begin miscompares++; $display("FAIL prio_int0: got %b want 1", INT0); end
    wr(4'h0, 16'h0028, 1, 1);
    rd(4'h8, d);
    vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL prio_vec_none: got %h want 0000", d); end
  endtask
  task automatic test_set_wins;
    wr(4'h6, 16'h0002, 1, 1);
    wr(4'h2, 16'h0002, 1, 1);
    IRQ[1] = 1;
    tick();
    IRQ[1] = 0;
    tick(4);
    vectors++; if (INT0 !== 1'b1) begin miscompares++; $display("FAIL setwin_int0_pre: got %b want 1", INT0); end
    IRQ[1] = 1;
    tick();
    IRQ[1] = 0;
    tick();
    ADDR = BASE; WDATA = 16'h0002; WRN0 = 0;
    tick();
    WRN0 = 1;
    rd(4'h0, d);
    vectors++; if (d !== 16'h0002) begin miscompares++; $display("FAIL setwin_pend: got %h want 0002", d); end
    tick();
    vectors++; if (INT0 !== 1'b1) begin miscompares++; $display("FAIL setwin_int0: got %b want 1", INT0); end
    wr(4'h0, 16'h0002, 1, 1);
    rd(4'h0, d);
    vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL setwin_w1c: got %h want 0000", d); end
  endtask
  task automatic test_lanes;
    wr(4'h2, 16'hABCD, 1, 0);
    rd(4'h2, d);
    vectors++; if (d !== 16'h00CD) begin miscompares++; $display("FAIL lane_low: got %h want 00cd", d); end
    ADDR = BASE | 16'h2; WDATA = 16'h1111; WRN0 = 0; WRN1 = 0;
    tick();
    WDATA = 16'h2222;
    tick(4);
    WRN0 = 1; WRN1 = 1;
    tick();
    rd(4'h2, d);
    vectors++; if (d !== 16'h1111) begin miscompares++; $display("FAIL lane_hold: got %h want 1111", d); end
    wr(4'h2, 16'h5AFF, 0, 1);
    rd(4'h2, d);
    vectors++; if (d !== 16'h5A11) begin miscompares++; $display("FAIL lane_high: got %h want 5a11", d); end
  endtask
  task automatic test_soft;
    wr(4'hA, 16'h0080, 1, 1);
    rd(4'h0, d);
    vectors++; if (d !== SOFT_EXP) begin miscompares++; $display("FAIL soft_pend: got %h want %h", d, SOFT_EXP); end
    rd(4'hA, d);
    vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL soft_read: got %h want 0000", d); end
    rd(4'hC, d);
    vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL rsvd_c: got %h want 0000", d); end
    tick();
    ADDR = BASE | 16'h2; RDN = 0;
    #1;
    vectors++; if (SEL !== 1'b1) begin miscompares++; $display("FAIL sel_in: got %b want 1", SEL); end
    ADDR = 16'hFE02;
    #1;
    vectors++; if (SEL !== 1'b0) begin miscompares++; $display("FAIL sel_out: got %b want 0", SEL); end
    vectors++; if (RDATA !== 16'h0000) begin miscompares++; $display("FAIL rdata_out: got %h want 0000", RDATA); end
    RDN = 1;
    tick();
  endtask
  initial begin
    tick(2);
    RESET = 0;
    tick();
    test_reset();
    test_edge();
    test_level();
    test_priority();
    test_set_wins();
    test_lanes();
    test_soft();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
